game_input_ctrl: RTL and testbench

GAME_INPUT_CTRL -- requirements
Module: game_input_ctrl

---
 rtl/game_input_ctrl.sv | 163 ++++++++++++++++
 tb/tb_game_input_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/game_input_ctrl.sv
// Game input controller: debounced buttons, IDLE/RUN/OVER sequencing,
// accelerating shift tick and a free-running 16-bit LFSR.
module game_input_ctrl #(
    parameter int BASE_PERIOD = 25_000_000,
    parameter int MIN_PERIOD  = 5_000_000,
    parameter int STEP        = 1_000_000,
    parameter int SCORE_STEP  = 50,
    parameter int DEBOUNCE    = 200_000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        btn_jump,
    input  logic        btn_start,
    input  logic        btn_quit,
    input  logic        game_over,
    input  logic [31:0] score,
    output logic        shift_enable,
    output logic        jump_trigger,
    output logic        start_game,
    output logic        force_game_over,
    output logic [15:0] rand_val,
    output logic [1:0]  state
);

    localparam int              DB_W       = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE - 1);
    localparam logic [31:0]     BASE_P32   = 32'(BASE_PERIOD);
    localparam logic [31:0]     MIN_P32    = 32'(MIN_PERIOD);
    localparam logic [31:0]     STEP_P32   = 32'(STEP);
    localparam logic [31:0]     SCORE_P32  = 32'(SCORE_STEP);
    localparam logic [15:0]     LFSR_SEED  = 16'hACE1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_OVER = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      btn_raw;
    logic [2:0]      sync_p0, sync_p1;
    logic [2:0]      db_lvl, db_prev;
    logic [DB_W-1:0] db_cnt [3];
    logic [2:0]      press;
    logic [31:0]     tick_q, active_q, period_q, thresh_q;
    logic            tick_expire;
    logic [15:0]     lfsr_q;

    function automatic logic [31:0] sat_thresh(input logic [31:0] t);
        if (t > (32'hFFFF_FFFF - SCORE_P32))
            return 32'hFFFF_FFFF;
        return t + SCORE_P32;
    endfunction

    function automatic logic [31:0] floor_period(input logic [31:0] p);
        if (p < (MIN_P32 + STEP_P32))
            return MIN_P32;
        return p - STEP_P32;
    endfunction

    assign btn_raw = {btn_quit, btn_start, btn_jump};

    // Stage p0/p1: two-flop synchronizer, then per-button debounce counter
    always_ff @(posedge CLK) begin
        if (!RST) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            db_lvl  <= '0;
            db_prev <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
            db_prev <= db_lvl;
            for (int i = 0; i < 3; i++) begin
                if (sync_p1[i] != db_lvl[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db_lvl[i] <= sync_p1[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign press       = db_lvl & ~db_prev;
    assign tick_expire = (tick_q == (active_q - 32'd1));

    always_ff @(posedge CLK) begin
        if (!RST) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (press[1]) state_d = S_RUN;
            S_RUN:   if (game_over) state_d = S_OVER;
            S_OVER:  if (press[1]) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // Pulses are held low while reset is asserted so nothing leaks out mid-reset
    always_comb begin
        shift_enable    = 1'b0;
        jump_trigger    = 1'b0;
        start_game      = 1'b0;
        force_game_over = 1'b0;
        if (RST) begin
            case (state_q)
                S_IDLE, S_OVER: start_game = press[1];
                S_RUN: begin
                    jump_trigger    = press[0];
                    force_game_over = press[2];
                    shift_enable    = tick_expire & ~game_over;
                end
                default: ;
            endcase
        end
    end

    // active_q is the period being counted; period_q is the speed-up target
    always_ff @(posedge CLK) begin
        if (!RST) begin
            tick_q   <= '0;
            active_q <= BASE_P32;
            period_q <= BASE_P32;
            thresh_q <= SCORE_P32;
        end else if (start_game) begin
            tick_q   <= '0;
            active_q <= BASE_P32;
            period_q <= BASE_P32;
            thresh_q <= SCORE_P32;
        end else if (state_q == S_RUN) begin
            if (shift_enable) begin
                tick_q   <= '0;
                active_q <= period_q;
            end else begin
                tick_q <= tick_q + 32'd1;
            end
            if (score >= thresh_q) begin
                thresh_q <= sat_thresh(thresh_q);
                period_q <= floor_period(period_q);
            end
        end else begin
            tick_q <= '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) lfsr_q <= LFSR_SEED;
        else      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    assign rand_val = lfsr_q;
    assign state    = state_q;

endmodule

// File: tb/tb_game_input_ctrl.sv
// Scoreboard bench for game_input_ctrl: stimulus queues expected pulses,
// a negedge monitor pops and compares them.
module tb_game_input_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        btn_jump, btn_start, btn_quit, game_over;
    logic [31:0] score;
    logic        shift_enable, jump_trigger, start_game, force_game_over;
    logic [15:0] rand_val;
    logic [1:0]  state;

    int cyc      = 0;
    int n_assert = 0;
    int n_fail   = 0;
    int seen [4] = '{0, 0, 0, 0};

    typedef struct {
        int kind;
        int cyc;
    } ev_t;
    ev_t exp_q [$];

    localparam int K_SHIFT = 0, K_JUMP = 1, K_START = 2, K_FORCE = 3;

    game_input_ctrl #(
        .BASE_PERIOD(10), .MIN_PERIOD(4), .STEP(2), .SCORE_STEP(5), .DEBOUNCE(3)
    ) dut (
        .CLK(CLK), .RST(RST),
        .btn_jump(btn_jump), .btn_start(btn_start), .btn_quit(btn_quit),
        .game_over(game_over), .score(score),
        .shift_enable(shift_enable), .jump_trigger(jump_trigger),
        .start_game(start_game), .force_game_over(force_game_over),
        .rand_val(rand_val), .state(state)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Monitor: every pulse observed must match the head of the expectation queue
    always @(negedge CLK) begin
        logic [3:0] p;
        ev_t        e;
        p = {force_game_over, start_game, jump_trigger, shift_enable};
        for (int k = 0; k < 4; k++) begin
            if (p[k]) begin
                seen[k]++;
                if (exp_q.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL unexpected pulse: kind %0d at cycle %0d, none required", k, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse kind", 32'(k), 32'(e.kind));
                    check("pulse cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        RST = 1'b0; btn_jump = 1'b0; btn_start = 1'b0; btn_quit = 1'b0;
        game_over = 1'b0; score = 32'd0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset state", 32'(state), 32'h0);
        check("reset rand", 32'(rand_val), 32'hACE1);
        check("reset shift", 32'(shift_enable), 32'h0);
        check("reset start", 32'(start_game), 32'h0);
        RST = 1'b1;
        goto(4);  check("lfsr step1", 32'(rand_val), 32'h5670);
        goto(5);  check("lfsr step2", 32'(rand_val), 32'hAB38);

        // Start held 10 cycles; speed-ups at 42/52/60/65; game_over on expiry at 80
        expect_ev(K_START, 10);
        expect_ev(K_SHIFT, 20); expect_ev(K_SHIFT, 30); expect_ev(K_SHIFT, 40);
        expect_ev(K_SHIFT, 50); expect_ev(K_SHIFT, 58); expect_ev(K_SHIFT, 64);
        expect_ev(K_SHIFT, 68); expect_ev(K_SHIFT, 72); expect_ev(K_SHIFT, 76);
        btn_start = 1'b1;
        goto(9);  check("idle before start", 32'(state), 32'h0);
        goto(11); check("run after start", 32'(state), 32'h1);
        goto(15); btn_start = 1'b0;
        goto(22); btn_jump = 1'b1;
        goto(24); btn_jump = 1'b0;
        goto(42); score = 32'd5;
        goto(52); score = 32'd10;
        goto(60); score = 32'd15;
        goto(65); score = 32'd20;
        goto(80); check("run before over", 32'(state), 32'h1);
        game_over = 1'b1;
        goto(81); check("over state", 32'(state), 32'h2);
        game_over = 1'b0; score = 32'd0;
        goto(82); btn_jump = 1'b1;
        goto(86); btn_jump = 1'b0;

        // Restart from OVER, jump and quit in RUN, then reset mid-RUN
        goto(90);
        expect_ev(K_START, 95); expect_ev(K_JUMP, 102); expect_ev(K_SHIFT, 105);
        expect_ev(K_FORCE, 112); expect_ev(K_SHIFT, 115);
        check("still over", 32'(state), 32'h2);
        btn_start = 1'b1;
        goto(96);  check("rerun state", 32'(state), 32'h1);
        goto(97);  btn_jump = 1'b1;
        goto(100); btn_start = 1'b0;
        goto(101); btn_jump = 1'b0;
        goto(107); btn_quit = 1'b1;
        goto(111); btn_quit = 1'b0;
        goto(118); RST = 1'b0;
        goto(119);
        check("midrun reset state", 32'(state), 32'h0);
        check("midrun reset rand", 32'(rand_val), 32'hACE1);
        RST = 1'b1;

        // Start and jump together in IDLE, then quit in RUN
        goto(140);
        check("idle after reset", 32'(state), 32'h0);
        expect_ev(K_START, 145); expect_ev(K_SHIFT, 155);
        expect_ev(K_FORCE, 161); expect_ev(K_SHIFT, 165);
        btn_start = 1'b1; btn_jump = 1'b1;
        goto(146); check("run after combo", 32'(state), 32'h1);
        goto(150); btn_start = 1'b0; btn_jump = 1'b0;
        goto(156); btn_quit = 1'b1;
        goto(160); btn_quit = 1'b0;
        goto(170);

        check("pending expectations", 32'(exp_q.size()), 32'd0);
        check("shift count", 32'(seen[K_SHIFT]), 32'd13);
        check("jump count", 32'(seen[K_JUMP]), 32'd1);
        check("start count", 32'(seen[K_START]), 32'd3);
        check("force count", 32'(seen[K_FORCE]), 32'd2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
